// File: rtl/field_extract_sched.sv
// Descriptor-driven field extractor: pulls big-endian 16/32/64-bit fields out of a
// 64-bit beat stream in descriptor order and emits them byte-reversed to host order.
module field_extract_sched #(
   parameter int NUM_FIELDS = 8,
   parameter int OFFSET_W   = 16,
   parameter int IDX_W      = $clog2(NUM_FIELDS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [IDX_W-1:0]    cfg_idx,
   input  logic [OFFSET_W-1:0] cfg_offset,
   input  logic [1:0]          cfg_size,
   input  logic                cfg_num_we,
   input  logic [IDX_W:0]      cfg_num,
   output logic                busy,
   input  logic [63:0]         s_data,
   input  logic                s_valid,
   input  logic                s_last,
   output logic                s_ready,
   output logic [63:0]         m_data,
   output logic [IDX_W-1:0]    m_idx,
   output logic                m_err,
   output logic                m_last,
   output logic                m_valid,
   input  logic                m_ready
);

   localparam int BW = OFFSET_W - 3;
   localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(NUM_FIELDS);

   typedef enum logic [2:0] {
      S_IDLE, S_HOLD, S_NEXT, S_FLUSH, S_DRAIN, S_DONE
   } state_t;

   state_t              r_state, w_state_next;
   logic [OFFSET_W-1:0] r_off  [NUM_FIELDS];
   logic [1:0]          r_size [NUM_FIELDS];
   logic [IDX_W:0]      r_num;
   logic [IDX_W:0]      r_fp, w_fp_next, w_fp_inc;
   logic [BW-1:0]       r_b, w_b_next;
   logic [63:0]         r_beat;
   logic                r_beat_last;
   logic [63:0]         r_m_data;
   logic [IDX_W-1:0]    r_m_idx;
   logic                r_m_err, r_m_last, r_m_valid;

   logic                w_busy, w_out_free, w_s_ready, w_beat_load;
   logic                w_load, w_load_err, w_bad;
   logic [OFFSET_W-1:0] w_d_off;
   logic [1:0]          w_d_size;
   logic [BW-1:0]       w_d_beat;
   logic [63:0]         w_shift, w_rev, w_field;

   assign w_busy     = (r_state != S_IDLE);
   assign w_out_free = !r_m_valid || m_ready;
   assign w_fp_inc   = r_fp + {{IDX_W{1'b0}}, 1'b1};
   assign w_d_off    = r_off[r_fp[IDX_W-1:0]];
   assign w_d_size   = r_size[r_fp[IDX_W-1:0]];
   assign w_d_beat   = w_d_off[OFFSET_W-1:3];

   always_comb begin
      w_bad = 1'b0;
      case (w_d_size)
         2'd0:    w_bad = w_d_off[0];
         2'd1:    w_bad = |w_d_off[1:0];
         2'd2:    w_bad = |w_d_off[2:0];
         default: w_bad = 1'b1;
      endcase
   end

   // Aligned fields never straddle a beat, so shift the first field byte to lane 0,
   // reverse all eight lanes, and keep the top n bytes.
   assign w_shift = r_beat >> {w_d_off[2:0], 3'b000};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_rev
         assign w_rev[8*(7-gi) +: 8] = w_shift[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      case (w_d_size)
         2'd0:    w_field = {48'h0, w_rev[63:48]};
         2'd1:    w_field = {32'h0, w_rev[63:32]};
         default: w_field = w_rev;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_fp_next    = r_fp;
      w_b_next     = r_b;
      w_s_ready    = 1'b0;
      w_beat_load  = 1'b0;
      w_load       = 1'b0;
      w_load_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_s_ready = 1'b1;
            if (s_valid) begin
               if (r_num == '0) begin
                  if (!s_last) w_state_next = S_DRAIN;
               end else begin
                  w_beat_load  = 1'b1;
                  w_b_next     = '0;
                  w_state_next = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (r_fp >= r_num) begin
               w_fp_next = '0;
               w_b_next  = '0;
               if (!r_beat_last)    w_state_next = S_DRAIN;
               else if (w_out_free) w_state_next = S_IDLE;
               else                 w_state_next = S_DONE;
            end else if (w_bad || w_d_beat < r_b) begin
               if (w_out_free) begin
                  w_load_err = 1'b1;
                  w_fp_next  = w_fp_inc;
               end
            end else if (w_d_beat == r_b) begin
               if (w_out_free) begin
                  w_load    = 1'b1;
                  w_fp_next = w_fp_inc;
               end
            end else begin
               w_b_next     = r_b + 1'b1;
               w_state_next = r_beat_last ? S_FLUSH : S_NEXT;
            end
         end
         S_NEXT: begin
            w_s_ready = 1'b1;
            if (s_valid) begin
               w_beat_load  = 1'b1;
               w_state_next = S_HOLD;
            end
         end
         S_FLUSH: begin
            if (r_fp >= r_num) begin
               w_fp_next    = '0;
               w_b_next     = '0;
               w_state_next = w_out_free ? S_IDLE : S_DONE;
            end else if (w_out_free) begin
               w_load_err = 1'b1;
               w_fp_next  = w_fp_inc;
            end
         end
         S_DRAIN: begin
            w_s_ready = 1'b1;
            if (s_valid && s_last) begin
               w_fp_next    = '0;
               w_b_next     = '0;
               w_state_next = w_out_free ? S_IDLE : S_DONE;
            end
         end
         S_DONE: begin
            if (w_out_free) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_fp        <= '0;
         r_b         <= '0;
         r_beat      <= '0;
         r_beat_last <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_fp    <= w_fp_next;
         r_b     <= w_b_next;
         if (w_beat_load) begin
            r_beat      <= s_data;
            r_beat_last <= s_last;
         end
      end
   end

   // The table only changes between packets so in-flight descriptors stay coherent.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_num <= '0;
         for (int i = 0; i < NUM_FIELDS; i++) begin
            r_off[i]  <= '0;
            r_size[i] <= '0;
         end
      end else if (!w_busy) begin
         if (cfg_we) begin
            r_off[cfg_idx]  <= cfg_offset;
            r_size[cfg_idx] <= cfg_size;
         end
         if (cfg_num_we) r_num <= (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_idx   <= '0;
         r_m_err   <= 1'b0;
         r_m_last  <= 1'b0;
      end else if (w_load || w_load_err) begin
         r_m_valid <= 1'b1;
         r_m_data  <= w_load ? w_field : 64'h0;
         r_m_idx   <= r_fp[IDX_W-1:0];
         r_m_err   <= w_load_err;
         r_m_last  <= (w_fp_inc == r_num);
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign busy    = w_busy;
   assign s_ready = w_s_ready;
   assign m_valid = r_m_valid;
   assign m_data  = r_m_data;
   assign m_idx   = r_m_idx;
   assign m_err   = r_m_err;
   assign m_last  = r_m_last;

endmodule

// File: tb/tb_field_extract_sched.sv
// Directed bench for field_extract_sched: hand-computed fields, errors, stalls and reset.
module tb_field_extract_sched;

   localparam int NF = 8;
   localparam int OW = 16;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we, cfg_num_we;
   logic [IW-1:0] cfg_idx;
   logic [OW-1:0] cfg_offset;
   logic [1:0]    cfg_size;
   logic [IW:0]   cfg_num;
   logic          busy;
   logic [63:0]   s_data;
   logic          s_valid, s_last, s_ready;
   logic [63:0]   m_data;
   logic [IW-1:0] m_idx;
   logic          m_err, m_last, m_valid, m_ready;

   int n_tests = 0;
   int n_fail  = 0;

   field_extract_sched #(.NUM_FIELDS(NF), .OFFSET_W(OW), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_offset(cfg_offset), .cfg_size(cfg_size),
      .cfg_num_we(cfg_num_we), .cfg_num(cfg_num), .busy(busy),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_idx(m_idx), .m_err(m_err), .m_last(m_last),
      .m_valid(m_valid), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_desc(input int idx, input int off, input int sz);
      cfg_we     = 1'b1;
      cfg_idx    = IW'(idx);
      cfg_offset = OW'(off);
      cfg_size   = 2'(sz);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic cfg_set_num(input int n);
      cfg_num_we = 1'b1;
      cfg_num    = (IW+1)'(n);
      tick();
      cfg_num_we = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic last);
      bit done = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      for (int i = 0; i < 100; i++) begin
         if (s_ready) begin
            tick();
            done = 1;
            break;
         end
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!done) check("s_ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic expect_out(input string tag, input int idx, input logic [63:0] d,
                             input logic err, input logic last);
      bit seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (m_valid) begin
            seen = 1;
            break;
         end
         tick();
      end
      check({tag, "_valid"}, 64'(m_valid), 64'd1);
      if (seen) begin
         check({tag, "_idx"},  64'(m_idx),  64'(idx));
         check({tag, "_data"}, m_data,      d);
         check({tag, "_err"},  64'(m_err),  64'(err));
         check({tag, "_last"}, 64'(m_last), 64'(last));
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_num_we = 1'b0; cfg_idx = '0; cfg_offset = '0;
      cfg_size = '0; cfg_num = '0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
      m_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_s_ready", 64'(s_ready), 64'd1);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data",  m_data,       64'd0);
      check("rst_m_idx",   64'(m_idx),   64'd0);
      check("rst_m_err",   64'(m_err),   64'd0);
      check("rst_m_last",  64'(m_last),  64'd0);
      check("rst_busy",    64'(busy),    64'd0);

      // Two fields from one beat, exact cycle timing
      cfg_desc(0, 2, 0);
      cfg_desc(1, 4, 1);
      cfg_set_num(2);
      s_valid = 1'b1; s_data = 64'h7766554433221100; s_last = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      check("t1_busy",     64'(busy),    64'd1);
      check("t1_s_ready",  64'(s_ready), 64'd0);
      check("t1_nvalid",   64'(m_valid), 64'd0);
      tick();
      check("t1_f0_valid", 64'(m_valid), 64'd1);
      check("t1_f0_idx",   64'(m_idx),   64'd0);
      check("t1_f0_data",  m_data,       64'h2233);
      check("t1_f0_err",   64'(m_err),   64'd0);
      check("t1_f0_last",  64'(m_last),  64'd0);
      tick();
      check("t1_f1_valid", 64'(m_valid), 64'd1);
      check("t1_f1_idx",   64'(m_idx),   64'd1);
      check("t1_f1_data",  m_data,       64'h44556677);
      check("t1_f1_last",  64'(m_last),  64'd1);
      tick();
      check("t1_end_valid", 64'(m_valid), 64'd0);
      check("t1_end_busy",  64'(busy),    64'd0);

      // 64-bit field in the second beat
      cfg_desc(0, 8, 2);
      cfg_set_num(1);
      fork
         begin
            send_beat(64'h7766554433221100, 1'b0);
            send_beat(64'hFFEEDDCCBBAA9988, 1'b1);
         end
         expect_out("t2", 0, 64'h8899AABBCCDDEEFF, 1'b0, 1'b1);
      join
      tick();
      check("t2_busy", 64'(busy), 64'd0);

      // Packet too short: both fields flushed as errors
      cfg_desc(0, 12, 0);
      cfg_desc(1, 4, 0);
      cfg_set_num(2);
      fork
         send_beat(64'h7766554433221100, 1'b1);
         begin
            expect_out("t3_f0", 0, 64'h0, 1'b1, 1'b0);
            expect_out("t3_f1", 1, 64'h0, 1'b1, 1'b1);
         end
      join
      tick();
      check("t3_busy", 64'(busy), 64'd0);

      // Misaligned error with output stalled
      cfg_desc(0, 3, 1);
      cfg_set_num(1);
      m_ready = 1'b0;
      send_beat(64'h7766554433221100, 1'b1);
      tick();
      check("t4_valid", 64'(m_valid), 64'd1);
      check("t4_err",   64'(m_err),   64'd1);
      check("t4_data",  m_data,       64'h0);
      check("t4_last",  64'(m_last),  64'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t4_stall%0d_valid", i), 64'(m_valid), 64'd1);
         check($sformatf("t4_stall%0d_err", i),   64'(m_err),   64'd1);
         check($sformatf("t4_stall%0d_idx", i),   64'(m_idx),   64'd0);
         check($sformatf("t4_stall%0d_sready", i), 64'(s_ready), 64'd0);
         check($sformatf("t4_stall%0d_busy", i),  64'(busy),    64'd1);
      end
      m_ready = 1'b1;
      tick();
      check("t4_end_valid", 64'(m_valid), 64'd0);
      check("t4_end_busy",  64'(busy),    64'd0);

      // num=0: packet drained without outputs
      cfg_set_num(0);
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = 64'(i); s_last = (i == 2);
         check($sformatf("t5_b%0d_sready", i), 64'(s_ready), 64'd1);
         tick();
         check($sformatf("t5_b%0d_mvalid", i), 64'(m_valid), 64'd0);
         check($sformatf("t5_b%0d_busy", i),   64'(busy),    64'(i < 2));
      end
      s_valid = 1'b0; s_last = 1'b0;

      // Good field, missing field, reserved size
      cfg_desc(0, 8, 0);
      cfg_desc(1, 0, 0);
      cfg_desc(2, 0, 3);
      cfg_set_num(3);
      fork
         begin
            send_beat(64'h7766554433221100, 1'b0);
            send_beat(64'hFFEEDDCCBBAA9988, 1'b1);
         end
         begin
            expect_out("t6_f0", 0, 64'h8899, 1'b0, 1'b0);
            expect_out("t6_f1", 1, 64'h0,    1'b1, 1'b0);
            expect_out("t6_f2", 2, 64'h0,    1'b1, 1'b1);
         end
      join

      // Full table across two beats, num write clamped from 15 to 8
      for (int k = 0; k < NF; k++) cfg_desc(k, 2 * k, 0);
      cfg_set_num(15);
      fork
         begin
            send_beat(64'h0706050403020100, 1'b0);
            send_beat(64'h0F0E0D0C0B0A0908, 1'b1);
         end
         begin
            for (int k = 0; k < NF; k++)
               expect_out($sformatf("t7_f%0d", k), k,
                          64'({8'(2 * k), 8'(2 * k + 1)}), 1'b0, (k == NF - 1));
         end
      join
      tick();
      check("t7_busy", 64'(busy), 64'd0);

      // Reset mid-packet, then config write while busy is ignored
      cfg_desc(0, 0, 0);
      cfg_desc(1, 2, 0);
      cfg_set_num(2);
      m_ready = 1'b0;
      send_beat(64'h7766554433221100, 1'b1);
      tick();
      check("t8_pre_valid", 64'(m_valid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_ready = 1'b1;
      check("t8_rst_valid",  64'(m_valid), 64'd0);
      check("t8_rst_sready", 64'(s_ready), 64'd1);
      check("t8_rst_busy",   64'(busy),    64'd0);
      s_valid = 1'b1; s_data = 64'h1; s_last = 1'b0;
      tick();
      s_valid = 1'b0;
      check("t8_num0_sready", 64'(s_ready), 64'd1);
      check("t8_num0_busy",   64'(busy),    64'd1);
      cfg_desc(0, 4, 1);
      send_beat(64'h2, 1'b1);
      check("t8_drain_busy", 64'(busy), 64'd0);
      cfg_set_num(1);
      fork
         send_beat(64'h7766554433221100, 1'b1);
         expect_out("t8_tbl", 0, 64'h0011, 1'b0, 1'b1);
      join
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
